// File: rtl/threaded_imem_pkg.sv
// Shared constants for the multi-thread instruction memory: widths, NOP encoding
// and the fetch fault codes.
package threaded_imem_pkg;

    localparam int XLEN         = 32;
    localparam int INSTR_WIDTH  = 32;
    localparam int THREAD_WIDTH = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_THREAD   = 2'b11
    } fault_e;

endpackage

// File: rtl/imem_bank.sv
// One thread's private instruction RAM: a synchronous read-first read port and
// an independent write port.
module imem_bank #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // NOTE: the array has no reset; clearing is done by the owner's sweep so
    // the storage maps onto plain RAM macros.
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: non-blocking assignments make a same-edge read see the old word,
    // which is exactly the read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/threaded_imem.sv
// Multi-thread instruction memory: INIT sweep to NOP, then fetch (valid/ready,
// one-cycle latency) and run-time programming of per-thread banks.
module threaded_imem
    import threaded_imem_pkg::*;
#(
    parameter int NUM_THREADS    = 8,
    parameter int DEPTH          = 256,
    parameter int XLEN           = threaded_imem_pkg::XLEN,
    parameter int INSTR_WIDTH    = threaded_imem_pkg::INSTR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_done,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [XLEN-1:0]         req_pc,
    input  logic [THREAD_WIDTH-1:0] req_thread,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [INSTR_WIDTH-1:0]  rsp_instr,
    output logic [XLEN-1:0]         rsp_pc,
    output logic [THREAD_WIDTH-1:0] rsp_thread,
    output logic [1:0]              rsp_fault,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    input  logic [THREAD_WIDTH-1:0] prog_thread,
    input  logic [AW-1:0]           prog_addr,
    input  logic [INSTR_WIDTH-1:0]  prog_data
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [INSTR_WIDTH-1:0]  NOP_W       = INSTR_WIDTH'(NOP);
    localparam logic [THREAD_WIDTH:0]   NT_LIMIT    = (THREAD_WIDTH + 1)'(NUM_THREADS);
    localparam logic [XLEN-1:0]         DEPTH_LIMIT = XLEN'(DEPTH);
    localparam logic [AW-1:0]           LAST_IDX    = AW'(DEPTH - 1);

    logic [0:0]             state;
    logic [AW-1:0]          cnt;
    logic                   run;
    logic                   sweep;
    logic                   accept;
    logic                   fetch_hit;
    fault_e                 req_fault;
    fault_e                 rsp_fault_q;
    logic                   rsp_hit;
    logic [AW-1:0]          word_idx;
    logic [INSTR_WIDTH-1:0] bank_rdata [NUM_THREADS];

    assign run        = (state == ST_RUN);
    assign sweep      = !run && CLEAR_ON_RESET;
    assign init_done  = run;
    assign prog_ready = run;
    assign req_ready  = run && (!rsp_valid || rsp_ready);
    assign accept     = req_valid && req_ready;
    assign word_idx   = req_pc[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            if (!CLEAR_ON_RESET || cnt == LAST_IDX) state <= ST_RUN;
            cnt <= cnt + AW'(1);
        end
    end

    // Bad thread outranks misalignment, which outranks out-of-range.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_fault = FAULT_NONE;
        if ({1'b0, req_thread} >= NT_LIMIT)
            req_fault = FAULT_THREAD;
        else if (req_pc[1:0] != 2'b00)
            req_fault = FAULT_MISALIGN;
        else if ((req_pc >> 2) >= DEPTH_LIMIT)
            req_fault = FAULT_RANGE;
    end

    assign fetch_hit = accept && (req_fault == FAULT_NONE);

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_bank
        logic                   we;
        logic                   re;
        logic [AW-1:0]          waddr;
        logic [INSTR_WIDTH-1:0] wdata;

        // The sweep writes every bank in parallel; in RUN only the addressed bank.
        assign we    = sweep || (run && prog_valid && prog_thread == THREAD_WIDTH'(t));
        assign waddr = run ? prog_addr : cnt;
        assign wdata = run ? prog_data : NOP_W;
        assign re    = fetch_hit && (req_thread == THREAD_WIDTH'(t));

        imem_bank #(
            .DEPTH (DEPTH),
            .WIDTH (INSTR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .re    (re),
            .raddr (word_idx),
            .rdata (bank_rdata[t])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_pc      <= '0;
            rsp_thread  <= '0;
            rsp_fault_q <= FAULT_NONE;
            rsp_hit     <= 1'b0;
        end else if (accept) begin
            rsp_valid   <= 1'b1;
            rsp_pc      <= req_pc;
            rsp_thread  <= req_thread;
            rsp_fault_q <= req_fault;
            rsp_hit     <= (req_fault == FAULT_NONE);
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

    assign rsp_fault = rsp_fault_q;

    // Bank read registers only move on an accepted fetch, so a stalled response
    // holds even if the captured word is reprogrammed meanwhile.
    always_comb begin
        rsp_instr = NOP_W;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (rsp_hit && rsp_thread == THREAD_WIDTH'(t)) rsp_instr = bank_rdata[t];
        end
    end

endmodule

// File: tb/tb_threaded_imem.sv
// Self-checking bench for threaded_imem: directed scenarios plus random fetches and
// writes checked against an array-based reference model.
module tb_threaded_imem;
    import threaded_imem_pkg::*;

    localparam int NT    = 6;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = THREAD_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_pc;
    logic [TW-1:0] req_thread;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [31:0]   rsp_pc;
    logic [TW-1:0] rsp_thread;
    logic [1:0]    rsp_fault;
    logic          prog_valid;
    logic          prog_ready;
    logic [TW-1:0] prog_thread;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [NT][DEPTH];

    threaded_imem #(
        .NUM_THREADS    (NT),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pc      (req_pc),
        .req_thread  (req_thread),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_pc      (rsp_pc),
        .rsp_thread  (rsp_thread),
        .rsp_fault   (rsp_fault),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_thread (prog_thread),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fault(input logic [TW-1:0] th, input logic [31:0] pc);
        if (int'(th) >= NT) return 2'b11;
        if (pc % 4 != 0) return 2'b01;
        if (pc / 4 >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [TW-1:0] th, input logic [31:0] pc);
        if (exp_fault(th, pc) != 2'b00) return NOP;
        return model[int'(th)][int'(pc / 4)];
    endfunction

    task automatic clear_model();
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < DEPTH; a++) model[t][a] = NOP;
    endtask

    // Called at a negedge with the block in RUN and no response pending.
    task automatic fetch(input logic [TW-1:0] th, input logic [31:0] pc, input string tag);
        logic [31:0] ei;
        logic [1:0]  ef;
        ei = exp_instr(th, pc);
        ef = exp_fault(th, pc);
        req_valid  = 1'b1;
        req_thread = th;
        req_pc     = pc;
        rsp_ready  = 1'b1;
        check({tag, ".req_ready"}, req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        check({tag, ".instr"}, rsp_instr, ei);
        check({tag, ".fault"}, rsp_fault, ef);
        check({tag, ".pc"}, rsp_pc, pc);
        check({tag, ".thread"}, rsp_thread, th);
        @(negedge clk);
        check({tag, ".drop"}, rsp_valid, 1'b0);
    endtask

    task automatic prog_write(input logic [TW-1:0] th, input logic [AW-1:0] addr,
                              input logic [31:0] data, input string tag);
        prog_valid  = 1'b1;
        prog_thread = th;
        prog_addr   = addr;
        prog_data   = data;
        check({tag, ".prog_ready"}, prog_ready, 1'b1);
        @(negedge clk);
        prog_valid = 1'b0;
        if (int'(th) < NT) model[int'(th)][int'(addr)] = data;
    endtask

    // Counts edges from rst deassertion until init_done, bounded.
    task automatic wait_init(input string tag);
        int cycles;
        cycles = 0;
        while (!init_done && cycles < 4 * DEPTH) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                check({tag, ".init_req_ready"}, req_ready, 1'b0);
                check({tag, ".init_prog_ready"}, prog_ready, 1'b0);
            end
        end
        check({tag, ".init_cycles"}, cycles, DEPTH);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_pc      = '0;
        req_thread  = '0;
        rsp_ready   = 1'b1;
        prog_valid  = 1'b0;
        prog_thread = '0;
        prog_addr   = '0;
        prog_data   = '0;
        clear_model();

        repeat (3) @(negedge clk);
        check("reset.rsp_valid", rsp_valid, 1'b0);
        check("reset.rsp_instr", rsp_instr, NOP);
        check("reset.rsp_pc", rsp_pc, 32'h0);
        check("reset.rsp_thread", rsp_thread, '0);
        check("reset.rsp_fault", rsp_fault, 2'b00);
        check("reset.init_done", init_done, 1'b0);
        check("reset.req_ready", req_ready, 1'b0);
        check("reset.prog_ready", prog_ready, 1'b0);

        rst = 1'b0;
        wait_init("init1");

        for (int t = 0; t < NT; t++) fetch(TW'(t), 32'h40, "nop_sweep");

        prog_write(3, 5, 32'h0050_0093, "w_t3a5");
        fetch(3, 32'h14, "rd_t3a5");
        fetch(2, 32'h14, "rd_t2a5");

        // Back-to-back fetches on thread 1, then a 3-cycle stall with a write to
        // the captured word.
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_thread = 1;
        req_pc     = 32'h0;
        check("b2b.req_ready", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b.rsp_valid", rsp_valid, 1'b1);
            check("b2b.rsp_pc", rsp_pc, 32'(i * 4));
            check("b2b.instr", rsp_instr, model[1][i]);
            if (i < 2) req_pc = 32'((i + 1) * 4);
        end
        req_pc      = 32'hC;
        rsp_ready   = 1'b0;
        prog_valid  = 1'b1;
        prog_thread = 1;
        prog_addr   = 2;
        prog_data   = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            prog_valid = 1'b0;
            check("stall.rsp_valid", rsp_valid, 1'b1);
            check("stall.rsp_pc", rsp_pc, 32'h8);
            check("stall.instr", rsp_instr, NOP);
            check("stall.fault", rsp_fault, 2'b00);
            check("stall.req_ready", req_ready, 1'b0);
        end
        model[1][2] = 32'hCAFE_F00D;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("unstall.rsp_pc", rsp_pc, 32'hC);
        check("unstall.rsp_valid", rsp_valid, 1'b1);
        @(negedge clk);
        check("unstall.drop", rsp_valid, 1'b0);
        fetch(1, 32'h8, "rd_after_stall_write");

        fetch(0, 32'h06, "f_misalign");
        fetch(0, 32'(DEPTH * 4), "f_range");
        fetch(7, 32'h06, "f_thread");
        fetch(6, 32'h00, "f_thread_edge");
        fetch(5, 32'((DEPTH - 1) * 4), "last_word");

        prog_write(0, 2, 32'h1111_1111, "w_t0a2");
        prog_write(8, 2, 32'hBAD0_BAD0, "w_dropped");
        fetch(0, 32'h8, "rd_after_drop");

        // Same-edge fetch and write to one word: read-first.
        req_valid   = 1'b1;
        req_thread  = 0;
        req_pc      = 32'h8;
        prog_valid  = 1'b1;
        prog_thread = 0;
        prog_addr   = 2;
        prog_data   = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid  = 1'b0;
        prog_valid = 1'b0;
        check("rfirst.instr", rsp_instr, 32'h1111_1111);
        model[0][2] = 32'hDEAD_BEEF;
        @(negedge clk);
        fetch(0, 32'h8, "rfirst.after");

        for (int i = 0; i < 60; i++) begin
            logic [TW-1:0] th;
            logic [31:0]   pc;
            th = TW'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                prog_write(th, AW'($urandom_range(0, DEPTH - 1)), $urandom, "rnd_w");
            end else begin
                if ($urandom_range(0, 3) == 0) pc = 32'($urandom_range(0, DEPTH * 4 + 16));
                else pc = 32'($urandom_range(0, DEPTH - 1) * 4);
                fetch(th, pc, "rnd_f");
            end
        end

        // Reset while a response is stalled.
        req_valid  = 1'b1;
        req_thread = 3;
        req_pc     = 32'h14;
        rsp_ready  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid.stalled", rsp_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.rsp_valid", rsp_valid, 1'b0);
        check("rst_mid.init_done", init_done, 1'b0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        wait_init("init2");
        clear_model();
        fetch(3, 32'h14, "reinit_t3a5");
        fetch(0, 32'h8, "reinit_t0a2");
        fetch(1, 32'h8, "reinit_t1a2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/threaded_imem.md
# threaded_imem

Parametrised multi-thread instruction memory for the barrel-threaded RISC-V fetch stage.
- Holds one private instruction bank per hardware thread and serves fetches for any thread selected per request.
- Fetches use a synchronous read behind a valid/ready handshake.
- Banks are loaded at run time through a program port, not only from files.
- After reset, every bank is cleared to NOP before fetches are accepted.

## Interface
Parameters:
- NUM_THREADS, 8: number of thread banks (≥1).
- DEPTH, 256: instruction words per bank (power of two).
- XLEN, 32: PC width.
- INSTR_WIDTH, 32: instruction width.
- CLEAR_ON_RESET, 1: if 1, reset sweeps all banks to NOP; if 0, the block goes straight to RUN.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done  out  1  high once the block is in RUN
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted this cycle when high together with req_valid
- req_pc  in  XLEN  byte PC
- req_thread  in  THREAD_WIDTH  bank select
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_instr  out  INSTR_WIDTH  fetched instruction (NOP on fault)
- rsp_pc  out  XLEN  echo of req_pc
- rsp_thread  out  THREAD_WIDTH  echo of req_thread
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 bad thread
- prog_valid  in  1  write request
- prog_ready  out  1  write accepted when high together with prog_valid
- prog_thread  in  THREAD_WIDTH  target bank
- prog_addr  in  $clog2(DEPTH)  word index
- prog_data  in  INSTR_WIDTH  instruction word

## Operation
States are INIT and RUN.
- rst forces INIT and clears the sweep counter.
- INIT: each cycle writes NOP (32'h00000013) at index cnt in all banks in parallel, then increments cnt.
- INIT → RUN after index DEPTH-1 is written, i.e. DEPTH cycles.
- In INIT, req_ready=0 and prog_ready=0.
- With CLEAR_ON_RESET=0, the block enters RUN on the first cycle after rst deasserts.

Fetch path:
- Word index is req_pc[AW+1:2], where AW = $clog2(DEPTH).
- Fault priority is bad thread (req_thread ≥ NUM_THREADS) > misaligned (req_pc[1:0]≠0) > out of range (req_pc[XLEN-1:2] ≥ DEPTH).
- A faulting request still produces a response: rsp_instr=NOP, fault code set, no bank access.

Program path:
- In RUN, prog_ready=1.
- An accepted write updates bank[prog_thread][prog_addr] at the clock edge.
- If prog_thread ≥ NUM_THREADS, the write is silently dropped.

Simultaneous fetch and write to the same bank and word:
- The fetch returns the old data (read-first).
- A later fetch returns the new data.

## Timing
- Reset values: rsp_valid=0, rsp_instr=NOP, rsp_pc=0, rsp_thread=0, rsp_fault=00, init_done=0, req_ready=0, prog_ready=0.
- req_ready = RUN && (!rsp_valid || rsp_ready).
- Latency: a request accepted at edge k gives rsp_valid=1 from edge k+1.
- Throughput: one fetch per cycle with rsp_ready held high.
- Stall (rsp_valid && !rsp_ready): all rsp_* outputs hold stable. This holds even if a prog write hits the captured bank and word during the stall; the held instr does not change.
- rsp_valid drops at the edge after the handshake unless a new request is accepted in that same cycle.
- rst mid-operation: any pending response is discarded (rsp_valid=0 next edge), the block re-enters INIT, and banks are re-cleared when CLEAR_ON_RESET=1.
- Writes are visible to a fetch accepted at least one cycle after the write edge.

## Structure
- Shared constants header/package holds XLEN, INSTR_WIDTH, THREAD_WIDTH, the NOP encoding and the fault-code enum (FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE, FAULT_THREAD).
- One sub-module, imem_bank: a DEPTH×INSTR_WIDTH RAM with one synchronous read-first read port and one write port, instantiated NUM_THREADS times through generate.
- The top level holds the INIT/RUN FSM, the sweep counter, fault decode, the response register and the output mux.

## Test plan
- Reset, then poll: init_done rises exactly DEPTH cycles after rst falls. Fetch pc=0x40 on every thread before any write → instr 0x00000013, fault 00.
- Write 0x00500093 to thread 3, addr 5, then fetch thread 3 pc=0x14 → 0x00500093 one cycle later. Thread 2 pc=0x14 → NOP.
- Back-to-back fetches pc=0,4,8 with rsp_ready=1 → three consecutive responses with matching rsp_pc. Then hold rsp_ready=0 for 3 cycles → outputs stable and req_ready=0.
- Fault cases:
  - pc=0x06 → fault 01.
  - pc=DEPTH*4 → fault 10.
  - pc=0x06 with thread ≥ NUM_THREADS (NUM_THREADS=6, thread 7) → fault 11.
  - Every fault case returns rsp_instr=NOP.
- Same-cycle fetch and write to thread 0, addr 2 (data 0xDEADBEEF over a previously written 0x11111111) → response 0x11111111. The next fetch → 0xDEADBEEF.
- Assert rst while rsp_valid=1 and stalled → rsp_valid=0 next edge, init_done=0. After re-init, previously written words read NOP.
